// File: rtl/dsp_mac_pipe.sv
// Parametrised signed MAC slice: tagged input/multiplier pipeline feeding a saturating post-adder.
// Optional pattern detector on the result register, enabled by defining DSP_MAC_PATDET_EN.
module dsp_mac_pipe #(
    parameter int unsigned A_WIDTH   = 18,
    parameter int unsigned B_WIDTH   = 18,
    parameter int unsigned P_WIDTH   = 48,
    parameter int unsigned IN_STAGES = 1,
    parameter int unsigned M_STAGES  = 1,
    parameter bit          SATURATE  = 1'b1
`ifdef DSP_MAC_PATDET_EN
    ,
    parameter logic [P_WIDTH-1:0] PATTERN = '0,
    parameter logic [P_WIDTH-1:0] MASK    = '0
`endif
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic               IN_VALID,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic [P_WIDTH-1:0] C,
    input  logic [P_WIDTH-1:0] PCIN,
    input  logic [2:0]         OP,
    input  logic               CLR_OVF,
    output logic               OUT_VALID,
    output logic [P_WIDTH-1:0] P,
    output logic [P_WIDTH-1:0] PCOUT,
    output logic               OVF,
`ifdef DSP_MAC_PATDET_EN
    output logic               PATDET,
`endif
    output logic               OVF_STICKY
);

    localparam int unsigned M_WIDTH = A_WIDTH + B_WIDTH;

    typedef struct packed {
        logic               vld;
        logic [2:0]         op;
        logic [P_WIDTH-1:0] c;
        logic [A_WIDTH-1:0] a;
        logic [B_WIDTH-1:0] b;
    } in_stage_t;

    typedef struct packed {
        logic               vld;
        logic [2:0]         op;
        logic [P_WIDTH-1:0] c;
        logic [M_WIDTH-1:0] m;
    } m_stage_t;

    in_stage_t in_now;
    in_stage_t mul_in;
    m_stage_t  mul_out;
    m_stage_t  fin;

    assign in_now = {IN_VALID, OP, C, A, B};

    generate
        if (IN_STAGES == 0) begin : g_in_bypass
            assign mul_in = in_now;
        end else begin : g_in_regs
            in_stage_t q [IN_STAGES];
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int unsigned i = 0; i < IN_STAGES; i++) q[i] <= '0;
                end else if (CE) begin
                    q[0] <= in_now;
                    for (int unsigned i = 1; i < IN_STAGES; i++) q[i] <= q[i-1];
                end
            end
            assign mul_in = q[IN_STAGES-1];
        end
    endgenerate

    // Operands are widened first so the product is formed at its full signed width.
    logic signed [M_WIDTH-1:0] a_ext;
    logic signed [M_WIDTH-1:0] b_ext;
    logic signed [M_WIDTH-1:0] prod;

    assign a_ext   = M_WIDTH'($signed(mul_in.a));
    assign b_ext   = M_WIDTH'($signed(mul_in.b));
    assign prod    = a_ext * b_ext;
    assign mul_out = {mul_in.vld, mul_in.op, mul_in.c, prod};

    generate
        if (M_STAGES == 0) begin : g_m_bypass
            assign fin = mul_out;
        end else begin : g_m_regs
            m_stage_t q [M_STAGES];
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int unsigned i = 0; i < M_STAGES; i++) q[i] <= '0;
                end else if (CE) begin
                    q[0] <= mul_out;
                    for (int unsigned i = 1; i < M_STAGES; i++) q[i] <= q[i-1];
                end
            end
            assign fin = q[M_STAGES-1];
        end
    endgenerate

    logic signed [P_WIDTH:0] m_w;
    logic signed [P_WIDTH:0] c_w;
    logic signed [P_WIDTH:0] p_w;
    logic signed [P_WIDTH:0] pcin_w;
    logic signed [P_WIDTH:0] sum_w;
    logic                    ovf_now;
    logic [P_WIDTH-1:0]      p_next;

    assign m_w    = (P_WIDTH+1)'($signed(fin.m));
    assign c_w    = (P_WIDTH+1)'($signed(fin.c));
    assign p_w    = (P_WIDTH+1)'($signed(P));
    assign pcin_w = (P_WIDTH+1)'($signed(PCIN));

    always_comb begin
        sum_w = m_w;
        case (fin.op)
            3'b001:  sum_w = c_w + m_w;
            3'b010:  sum_w = p_w + m_w;
            3'b011:  sum_w = p_w - m_w;
            3'b100:  sum_w = c_w - m_w;
            3'b101:  sum_w = pcin_w + m_w;
            default: sum_w = m_w;
        endcase
    end

    // One guard bit: the sum left the P_WIDTH range when the top two bits disagree.
    assign ovf_now = sum_w[P_WIDTH] ^ sum_w[P_WIDTH-1];

    always_comb begin
        p_next = sum_w[P_WIDTH-1:0];
        if (SATURATE && ovf_now) begin
            p_next = sum_w[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P         <= '0;
            OUT_VALID <= 1'b0;
            OVF       <= 1'b0;
        end else if (CE) begin
            OUT_VALID <= fin.vld;
            OVF       <= fin.vld & ovf_now;
            if (fin.vld) P <= p_next;
        end
    end

    // Clear works regardless of CE; a simultaneous overflow keeps the flag set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF_STICKY <= 1'b0;
        end else if (CE && fin.vld && ovf_now) begin
            OVF_STICKY <= 1'b1;
        end else if (CLR_OVF) begin
            OVF_STICKY <= 1'b0;
        end
    end

`ifdef DSP_MAC_PATDET_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PATDET <= 1'b0;
        end else if (CE && fin.vld) begin
            PATDET <= ((p_next ^ PATTERN) & ~MASK) == '0;
        end
    end
`endif

    assign PCOUT = P;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: a saturating default-depth slice and a wrapping 2+0-stage slice share stimulus,
// both checked each cycle against a queue/arithmetic reference model plus directed constant checks.
module tb_dsp_mac_pipe;

    localparam int AW = 18;
    localparam int BW = 18;
    localparam int PW = 48;
    localparam int L  = 3;
    localparam longint PMAX = (longint'(1) <<< 47) - 1;
    localparam longint PMIN = -(longint'(1) <<< 47);
    localparam logic [PW-1:0] PAT = 48'd57;
    localparam logic [PW-1:0] MSK = '0;

    logic          CLK = 1'b0;
    logic          RST, CE, IN_VALID, CLR_OVF;
    logic [AW-1:0] A;
    logic [BW-1:0] B;
    logic [PW-1:0] C, PCIN;
    logic [2:0]    OP;

    logic          vs, ovs, sts, vw, ovw, stw;
    logic [PW-1:0] ps, pcs, pw, pcw;
`ifdef DSP_MAC_PATDET_EN
    logic          pds, pdw;
`endif

    always #5 CLK = ~CLK;

    dsp_mac_pipe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW),
        .IN_STAGES(1), .M_STAGES(1), .SATURATE(1'b1)
`ifdef DSP_MAC_PATDET_EN
        , .PATTERN(PAT), .MASK(MSK)
`endif
    ) dut_sat (
        .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID), .A(A), .B(B), .C(C),
        .PCIN(PCIN), .OP(OP), .CLR_OVF(CLR_OVF), .OUT_VALID(vs), .P(ps), .PCOUT(pcs),
        .OVF(ovs),
`ifdef DSP_MAC_PATDET_EN
        .PATDET(pds),
`endif
        .OVF_STICKY(sts)
    );

    dsp_mac_pipe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW),
        .IN_STAGES(2), .M_STAGES(0), .SATURATE(1'b0)
`ifdef DSP_MAC_PATDET_EN
        , .PATTERN(PAT), .MASK(MSK)
`endif
    ) dut_wrap (
        .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID), .A(A), .B(B), .C(C),
        .PCIN(PCIN), .OP(OP), .CLR_OVF(CLR_OVF), .OUT_VALID(vw), .P(pw), .PCOUT(pcw),
        .OVF(ovw),
`ifdef DSP_MAC_PATDET_EN
        .PATDET(pdw),
`endif
        .OVF_STICKY(stw)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit       vld;
        bit [2:0] op;
        longint   a, b, c;
    } ent_t;

    ent_t   q[$];
    longint mp  [2];
    bit     mv  [2];
    bit     mo  [2];
    bit     ms  [2];
    bit     mpd [2];

    function automatic logic [63:0] w48(input longint v);
        return {16'b0, v[47:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void compute(input longint prev, input ent_t e, input longint pcin,
                                    input bit sat, output longint np, output bit ov);
        longint m, s;
        logic [47:0] t;
        m = e.a * e.b;
        case (e.op)
            3'd1:    s = e.c + m;
            3'd2:    s = prev + m;
            3'd3:    s = prev - m;
            3'd4:    s = e.c - m;
            3'd5:    s = pcin + m;
            default: s = m;
        endcase
        ov = (s > PMAX) || (s < PMIN);
        if (!ov)     np = s;
        else if (sat) np = (s > 0) ? PMAX : PMIN;
        else begin
            t  = s[47:0];
            np = longint'($signed(t));
        end
    endfunction

    task automatic model_reset();
        ent_t b;
        b.vld = 0; b.op = 0; b.a = 0; b.b = 0; b.c = 0;
        q.delete();
        for (int i = 0; i < L - 1; i++) q.push_back(b);
        for (int k = 0; k < 2; k++) begin
            mp[k] = 0; mv[k] = 0; mo[k] = 0; ms[k] = 0; mpd[k] = 0;
        end
    endtask

    task automatic model_edge();
        ent_t   e, f;
        bit     fired, ov;
        longint np;
        logic [47:0] t;
        if (RST) begin
            model_reset();
            return;
        end
        fired = 0;
        if (CE) begin
            e.vld = IN_VALID; e.op = OP;
            e.a = longint'($signed(A)); e.b = longint'($signed(B)); e.c = longint'($signed(C));
            q.push_back(e);
            f = q.pop_front();
            fired = f.vld;
            for (int k = 0; k < 2; k++) begin
                if (f.vld) begin
                    compute(mp[k], f, longint'($signed(PCIN)), (k == 0), np, ov);
                    mp[k] = np; mv[k] = 1; mo[k] = ov;
                    t = np[47:0];
                    mpd[k] = ((t ^ PAT) & ~MSK) == '0;
                end else begin
                    mv[k] = 0; mo[k] = 0;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (fired && mo[k]) ms[k] = 1;
            else if (CLR_OVF)   ms[k] = 0;
        end
    endtask

    task automatic check_all();
        chk("s_p",      ps,  w48(mp[0]));
        chk("s_pcout",  pcs, w48(mp[0]));
        chk("s_vld",    vs,  mv[0]);
        chk("s_ovf",    ovs, mo[0]);
        chk("s_sticky", sts, ms[0]);
        chk("w_p",      pw,  w48(mp[1]));
        chk("w_pcout",  pcw, w48(mp[1]));
        chk("w_vld",    vw,  mv[1]);
        chk("w_ovf",    ovw, mo[1]);
        chk("w_sticky", stw, ms[1]);
`ifdef DSP_MAC_PATDET_EN
        chk("s_patdet", pds, mpd[0]);
        chk("w_patdet", pdw, mpd[1]);
`endif
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input bit [2:0] op, input int a, input int b, input longint c);
        IN_VALID = v;
        OP       = op;
        A        = a[AW-1:0];
        B        = b[BW-1:0];
        C        = c[PW-1:0];
    endtask

    longint acc_exp [6] = '{1, 15, 29, 43, 57, 43};
    bit     sc_ce   [15] = '{1,1,1,1,0,0,0,1,1,1,1,1,1,1,1};
    bit     sc_v    [15] = '{1,1,0,0,1,1,1,1,1,1,0,0,0,0,0};
    int     nres;

    initial begin
        RST = 1; CE = 1; IN_VALID = 0; CLR_OVF = 0;
        A = '0; B = '0; C = '0; PCIN = '0; OP = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_p", ps, 0);
        chk("rst_vld", vs, 0);
        chk("rst_ovf", ovs, 0);
        chk("rst_sticky", sts, 0);
        check_all();
        RST = 0;

        // Reset in the middle of a stream
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'd0, int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)), 0);
            cyc();
        end
        #2 RST = 1;
        #1 model_reset();
        chk("rst_mid_p", ps, 0);
        chk("rst_mid_vld", vs, 0);
        chk("rst_mid_sticky", sts, 0);
        chk("rst_mid_wp", pw, 0);
        check_all();
        #1 RST = 0;
        IN_VALID = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_quiet_s", vs, 0);
            chk("rst_quiet_w", vw, 0);
        end

        // Latency
        drive(1, 3'd0, 3, -5, 0);
        cyc();
        IN_VALID = 0;
        chk("lat_c1", vs, 0);
        cyc();
        chk("lat_c2", vs, 0);
        cyc();
        chk("lat_c3_vld", vs, 1);
        chk("lat_c3_p", ps, w48(-15));
        chk("lat_c3_wp", pw, w48(-15));
        cyc();
        chk("lat_c4", vs, 0);

        // Accumulate / subtract back-to-back
        nres = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      drive(1, 3'd0, 1, 1, 0);
            else if (i < 5)  drive(1, 3'd2, 2, 7, 0);
            else if (i == 5) drive(1, 3'd3, 2, 7, 0);
            else             IN_VALID = 0;
            cyc();
            if (vs) begin
                if (nres < 6) begin
                    chk("acc_p", ps, w48(acc_exp[nres]));
`ifdef DSP_MAC_PATDET_EN
                    chk("acc_patdet", pds, acc_exp[nres] == 57);
`endif
                end
                nres++;
            end
        end
        chk("acc_count", nres, 6);

        // Bubbles and clock-enable freeze
        nres = 0;
        for (int i = 0; i < 15; i++) begin
            CE = sc_ce[i];
            if (!sc_ce[i])    drive(1, 3'd2, 5, 5, 0);
            else if (i == 0)  drive(sc_v[i], 3'd0, 1, 1, 0);
            else              drive(sc_v[i], 3'd2, 2, 7, 0);
            cyc();
            if (!sc_ce[i]) begin
                chk("ce_frz_vld", vs, 1);
                chk("ce_frz_p", ps, w48(15));
            end
            if (sc_ce[i] && vs) nres++;
        end
        CE = 1;
        chk("ce_final_p", ps, w48(57));
        chk("ce_count", nres, 5);

        // Positive saturation / wrap
        drive(1, 3'd1, 1, 1, PMAX);
        cyc();
        IN_VALID = 0;
        cyc();
        cyc();
        chk("sat_p", ps, w48(PMAX));
        chk("sat_ovf", ovs, 1);
        chk("sat_sticky", sts, 1);
        chk("wrap_p", pw, w48(PMIN));
        chk("wrap_ovf", ovw, 1);
        cyc();
        chk("sat_ovf_pulse", ovs, 0);
        chk("sat_sticky_hold", sts, 1);
        CLR_OVF = 1;
        cyc();
        CLR_OVF = 0;
        chk("clr_sticky", sts, 0);

        // Negative saturation with clear in the overflow cycle
        drive(1, 3'd4, 1, 1, PMIN);
        cyc();
        IN_VALID = 0;
        cyc();
        CLR_OVF = 1;
        cyc();
        CLR_OVF = 0;
        chk("nsat_p", ps, w48(PMIN));
        chk("nwrap_p", pw, w48(PMAX));
        chk("set_wins_sticky", sts, 1);
        chk("set_wins_ovf", ovs, 1);
        CE = 0;
        CLR_OVF = 1;
        cyc();
        CLR_OVF = 0;
        CE = 1;
        chk("clr_ce0_sticky", sts, 0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            CE       = ($urandom_range(0, 9) != 0);
            IN_VALID = ($urandom_range(0, 9) < 7);
            OP       = 3'($urandom_range(0, 7));
            A        = AW'($urandom());
            B        = BW'($urandom());
            if ($urandom_range(0, 3) == 0) C = PW'({$urandom(), $urandom()});
            else                           C = PW'($signed(AW'($urandom())));
            if ($urandom_range(0, 3) == 0) PCIN = PW'({$urandom(), $urandom()});
            else                           PCIN = PW'($signed(AW'($urandom())));
            CLR_OVF = ($urandom_range(0, 19) == 0);
            cyc();
        end
        CE = 1; IN_VALID = 0; CLR_OVF = 0;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
